// File: rtl/shadow_capture_ring.sv
`default_nettype none
// ============================================================================
// Module   : shadow_capture_ring
// Brief    : DEPTH-entry snapshot ring, dumped oldest-first over CHAINS_OUT
//            serial chains. Optional macro SHADOW_CAPTURE_PARITY_EN appends an
//            even-parity bit to every chain slice.
// Revision : 1.0 - initial release
// ============================================================================
module shadow_capture_ring #(
  parameter int DFF_BITS   = 38,
  parameter int DEPTH      = 4,
  parameter int CHAINS_OUT = 1
) (
  input  logic                    sh_clk,
  input  logic                    sh_rst,
  input  logic                    capture_en,
  input  logic [DFF_BITS-1:0]     din,
  input  logic                    dump_en,
  output logic [CHAINS_OUT-1:0]   chains_out,
  output logic                    chains_out_vld,
  output logic                    chains_out_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int AW    = $clog2(DEPTH);
  localparam int BPC   = (DFF_BITS + CHAINS_OUT - 1) / CHAINS_OUT;
  localparam int PAD_W = BPC * CHAINS_OUT;
`ifdef SHADOW_CAPTURE_PARITY_EN
  localparam int SHIFT_LEN = BPC + 1;
  localparam int ENTRY_W   = DFF_BITS + CHAINS_OUT;
`else
  localparam int SHIFT_LEN = BPC;
  localparam int ENTRY_W   = DFF_BITS;
`endif
  localparam int CW = $clog2(SHIFT_LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DUMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_bit_cnt;
  logic [ENTRY_W-1:0]    r_mem [DEPTH];

  logic                  w_cap;
  logic [AW-1:0]         w_wr_next;
  logic [AW:0]           w_fill_next;
  logic [ENTRY_W-1:0]    w_entry_in;
  logic [ENTRY_W-1:0]    w_rd_entry;
  logic [PAD_W-1:0]      w_rd_pad;
  logic [CHAINS_OUT-1:0] w_bits;
`ifdef SHADOW_CAPTURE_PARITY_EN
  logic [PAD_W-1:0]      w_din_pad;
`endif

  // busy lags the state by one edge, so it also blocks the capture on the
  // first IDLE edge after DONE.
  assign w_cap       = (r_state == S_IDLE) && !busy && capture_en;
  assign w_wr_next   = w_cap ? r_wr_ptr + AW'(1) : r_wr_ptr;
  assign w_fill_next = (w_cap && fill != (AW+1)'(DEPTH)) ? fill + (AW+1)'(1) : fill;
  assign w_rd_entry  = r_mem[r_rd_ptr];

  always_comb begin
    w_entry_in = '0;
    w_entry_in[DFF_BITS-1:0] = din;
`ifdef SHADOW_CAPTURE_PARITY_EN
    w_din_pad = '0;
    w_din_pad[DFF_BITS-1:0] = din;
    for (int c = 0; c < CHAINS_OUT; c++)
      w_entry_in[DFF_BITS + c] = ^w_din_pad[c*BPC +: BPC];
`endif
  end

  // Zero-padded view of the entry being shifted; pad bits only reach the last chain.
  always_comb begin
    w_rd_pad = '0;
    w_rd_pad[DFF_BITS-1:0] = w_rd_entry[DFF_BITS-1:0];
    w_bits = '0;
    for (int c = 0; c < CHAINS_OUT; c++) begin
      for (int b = 0; b < BPC; b++)
        if (r_bit_cnt == CW'(b)) w_bits[c] = w_rd_pad[c*BPC + b];
`ifdef SHADOW_CAPTURE_PARITY_EN
      if (r_bit_cnt == CW'(BPC)) w_bits[c] = w_rd_entry[DFF_BITS + c];
`endif
    end
  end

  always_ff @(posedge sh_clk) begin
    if (w_cap) r_mem[r_wr_ptr] <= w_entry_in;
  end

  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      r_state         <= S_IDLE;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_bit_cnt       <= '0;
      fill            <= '0;
      chains_out      <= '0;
      chains_out_vld  <= 1'b0;
      chains_out_done <= 1'b0;
      busy            <= 1'b0;
    end else begin
      busy            <= (r_state != S_IDLE);
      chains_out_vld  <= 1'b0;
      chains_out_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wr_ptr <= w_wr_next;
          fill     <= w_fill_next;
          if (dump_en) begin
            r_bit_cnt <= '0;
            r_rd_ptr  <= w_wr_next - w_fill_next[AW-1:0];
            r_state   <= (w_fill_next != '0) ? S_DUMP : S_DONE;
          end
        end
        S_DUMP: begin
          if (dump_en) begin
            chains_out     <= w_bits;
            chains_out_vld <= 1'b1;
            if (r_bit_cnt == CW'(SHIFT_LEN - 1)) begin
              r_bit_cnt <= '0;
              // The newest entry always sits just behind the write pointer.
              if (r_rd_ptr == r_wr_ptr - AW'(1)) r_state <= S_DONE;
              else                               r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          chains_out_done <= 1'b1;
          fill            <= '0;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shadow_capture_ring.sv
`default_nettype none
// Bench for shadow_capture_ring: a 1-chain/depth-4 and a 3-chain/depth-8 instance
// checked every cycle against a snapshot-queue / bit-stream model.
module tb_shadow_capture_ring;
  localparam int NB = 38;
`ifdef SHADOW_CAPTURE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int SH_A = 38 + PAR;
  localparam int SH_B = 13 + PAR;
  localparam int P_IDLE = 0, P_DUMP = 1, P_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       cap_en = '0, dump_en_v = '0;
  logic [1:0][37:0] din_v = '0;
  logic             co_a;
  logic [2:0]       co_b;
  logic             vld_a, vld_b, done_a, done_b, busy_a, busy_b;
  logic [2:0]       fill_a;
  logic [3:0]       fill_b;
  logic [1:0]       act_vld, act_done, act_busy;
  logic [1:0][3:0]  act_fill;
  logic [1:0][2:0]  act_co;

  assign act_vld  = {vld_b, vld_a};
  assign act_done = {done_b, done_a};
  assign act_busy = {busy_b, busy_a};
  assign act_fill = {fill_b, {1'b0, fill_a}};
  assign act_co   = {co_b, {2'b00, co_a}};

  shadow_capture_ring #(.DFF_BITS(38), .DEPTH(4), .CHAINS_OUT(1)) u_dut_a (
    .sh_clk(clk), .sh_rst(rst), .capture_en(cap_en[0]), .din(din_v[0]),
    .dump_en(dump_en_v[0]), .chains_out(co_a), .chains_out_vld(vld_a),
    .chains_out_done(done_a), .busy(busy_a), .fill(fill_a));

  shadow_capture_ring #(.DFF_BITS(38), .DEPTH(8), .CHAINS_OUT(3)) u_dut_b (
    .sh_clk(clk), .sh_rst(rst), .capture_en(cap_en[1]), .din(din_v[1]),
    .dump_en(dump_en_v[1]), .chains_out(co_b), .chains_out_vld(vld_b),
    .chains_out_done(done_b), .busy(busy_b), .fill(fill_b));

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, i, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [37:0]     snaps  [2][8];
  logic [2:0]      stream [2][160];
  int              nsnap [2], slen [2], spos [2], phase [2];
  logic [1:0]      m_vld = '0, m_done = '0, m_busy = '0;
  logic [1:0][2:0] m_out = '0;

  function automatic int chains_of(input int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int depth_of(input int i);  return (i == 0) ? 4 : 8; endfunction
  function automatic logic sbit(input logic [37:0] s, input int idx);
    return (idx < NB) ? s[idx] : 1'b0;
  endfunction

  task automatic push_snap(input int i, input logic [37:0] d);
    if (nsnap[i] == depth_of(i)) begin
      for (int k = 0; k < nsnap[i] - 1; k++) snaps[i][k] = snaps[i][k+1];
      snaps[i][nsnap[i]-1] = d;
    end else begin
      snaps[i][nsnap[i]] = d;
      nsnap[i]++;
    end
  endtask

  task automatic build_stream(input int i);
    int c = chains_of(i);
    int bpc = (NB + c - 1) / c;
    logic [2:0] v;
    logic p;
    slen[i] = 0;
    spos[i] = 0;
    for (int e = 0; e < nsnap[i]; e++)
      for (int b = 0; b < bpc + PAR; b++) begin
        v = '0;
        for (int ch = 0; ch < c; ch++) begin
          if (b < bpc) v[ch] = sbit(snaps[i][e], ch*bpc + b);
          else begin
            p = 1'b0;
            for (int k = 0; k < bpc; k++) p ^= sbit(snaps[i][e], ch*bpc + k);
            v[ch] = p;
          end
        end
        stream[i][slen[i]] = v;
        slen[i]++;
      end
  endtask

  task automatic model_step(input int i);
    logic nb = (phase[i] != P_IDLE);
    m_vld[i]  = 1'b0;
    m_done[i] = 1'b0;
    case (phase[i])
      P_IDLE: begin
        if (cap_en[i] && !m_busy[i]) push_snap(i, din_v[i]);
        if (dump_en_v[i]) begin
          build_stream(i);
          phase[i] = (nsnap[i] > 0) ? P_DUMP : P_DONE;
        end
      end
      P_DUMP: if (dump_en_v[i]) begin
        m_out[i] = stream[i][spos[i]];
        m_vld[i] = 1'b1;
        spos[i]++;
        if (spos[i] == slen[i]) phase[i] = P_DONE;
      end
      default: begin
        m_done[i] = 1'b1;
        nsnap[i]  = 0;
        phase[i]  = P_IDLE;
      end
    endcase
    m_busy[i] = nb;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        nsnap[i] = 0; phase[i] = P_IDLE; slen[i] = 0; spos[i] = 0;
      end
      m_vld = '0; m_done = '0; m_busy = '0; m_out = '0;
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare and bit collector ----------------
  always @(negedge clk) begin
    if (chk_on)
      for (int i = 0; i < 2; i++) begin
        chk("vld",  i, 64'(act_vld[i]),  64'(m_vld[i]));
        chk("done", i, 64'(act_done[i]), 64'(m_done[i]));
        chk("busy", i, 64'(act_busy[i]), 64'(m_busy[i]));
        chk("fill", i, 64'(act_fill[i]), 64'(nsnap[i]));
        chk("data", i, 64'(act_co[i]),   64'(m_out[i]));
      end
  end

  logic [2:0] col [2][4096];
  int         col_n [2];
  initial begin col_n[0] = 0; col_n[1] = 0; end
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (act_vld[i] === 1'b1) begin
        col[i][col_n[i] % 4096] = act_co[i];
        col_n[i]++;
      end

  function automatic logic [63:0] assemble(input int i, input int start, input int ch, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = col[i][(start + k) % 4096][ch];
    return r;
  endfunction

  function automatic logic [37:0] rand38();
    logic [63:0] t = {$urandom(), $urandom()};
    return t[37:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int i, input logic [37:0] d);
    cap_en[i] = 1'b1;
    din_v[i]  = d;
    tick();
    cap_en[i] = 1'b0;
  endtask

  task automatic run_dump(input int i, input int pause_at, input bit rnd, output int nv);
    bit got = 1'b0;
    bit paused = 1'b0;
    nv = 0;
    dump_en_v[i] = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      tick();
      cap_en[i] = 1'b0;
      if (act_done[i]) begin got = 1'b1; break; end
      if (act_vld[i]) nv++;
      if (rnd) begin
        dump_en_v[i] = ($urandom_range(0, 3) != 0);
        cap_en[i]    = ($urandom_range(0, 4) == 0);
        din_v[i]     = rand38();
      end else if (nv == pause_at && !paused) begin
        paused = 1'b1;
        dump_en_v[i] = 1'b0;
        for (int p = 0; p < 5; p++) begin
          cap_en[i] = ~cap_en[i];
          din_v[i]  = rand38();
          tick();
          chk("pause_vld",  i, 64'(act_vld[i]),  64'd0);
          chk("pause_fill", i, 64'(act_fill[i]), 64'd1);
        end
        cap_en[i] = 1'b0;
        dump_en_v[i] = 1'b1;
      end
    end
    dump_en_v[i] = 1'b0;
    cap_en[i] = 1'b0;
    chk("done_seen", i, 64'(got), 64'd1);
  endtask

  initial begin
    int nv, st;
    logic [37:0] x;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_fill", 0, 64'(act_fill[0]), 64'd0);
    chk("rst_busy", 0, 64'(act_busy[0]), 64'd0);
    chk_on = 1'b1;

    // Basic dump
    capture(0, 38'h2A_1234_5678);
    chk("t1_fill", 0, 64'(act_fill[0]), 64'd1);
    st = col_n[0];
    run_dump(0, -1, 1'b0, nv);
    chk("t1_nvld", 0, 64'(nv), 64'(SH_A));
    chk("t1_data", 0, assemble(0, st, 0, 38), 64'h2A_1234_5678);
    chk("t1_fill_done", 0, 64'(act_fill[0]), 64'd0);
    tick();

    // Wrap-around
    for (int v = 1; v <= 6; v++) capture(0, 38'(v));
    chk("t2_fill", 0, 64'(act_fill[0]), 64'd4);
    st = col_n[0];
    run_dump(0, -1, 1'b0, nv);
    chk("t2_nvld", 0, 64'(nv), 64'(4 * SH_A));
    for (int e = 0; e < 4; e++)
      chk("t2_entry", e, assemble(0, st + e * SH_A, 0, 38), 64'(3 + e));
    tick();

    // Multi-chain padding
    capture(1, '1);
    st = col_n[1];
    run_dump(1, -1, 1'b0, nv);
    chk("t3_nvld", 1, 64'(nv), 64'(SH_B));
    chk("t3_ch0", 1, assemble(1, st, 0, 13), 64'h1FFF);
    chk("t3_ch1", 1, assemble(1, st, 1, 13), 64'h1FFF);
    chk("t3_ch2", 1, assemble(1, st, 2, 13), 64'h0FFF);
    tick();

    // Pause with frozen capture
    x = rand38();
    capture(0, x);
    st = col_n[0];
    run_dump(0, 10, 1'b0, nv);
    chk("t4_nvld", 0, 64'(nv), 64'(SH_A));
    chk("t4_data", 0, assemble(0, st, 0, 38), 64'(x));
    tick();

    // Empty dump, then simultaneous capture + dump
    dump_en_v[0] = 1'b1;
    tick();
    dump_en_v[0] = 1'b0;
    chk("t5_done_early", 0, 64'(act_done[0]), 64'd0);
    tick();
    chk("t5_done", 0, 64'(act_done[0]), 64'd1);
    chk("t5_vld",  0, 64'(act_vld[0]),  64'd0);
    tick();
    chk("t5_busy", 0, 64'(act_busy[0]), 64'd0);
    x = rand38();
    cap_en[0] = 1'b1;
    din_v[0]  = x;
    st = col_n[0];
    run_dump(0, -1, 1'b0, nv);
    chk("t5_nvld", 0, 64'(nv), 64'(SH_A));
    chk("t5_data", 0, assemble(0, st, 0, 38), 64'(x));
    tick();

    // Reset mid-dump
    capture(0, rand38());
    capture(0, rand38());
    dump_en_v[0] = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dump_en_v[0] = 1'b0;
    chk("t6_vld",  0, 64'(act_vld[0]),  64'd0);
    chk("t6_done", 0, 64'(act_done[0]), 64'd0);
    chk("t6_busy", 0, 64'(act_busy[0]), 64'd0);
    chk("t6_fill", 0, 64'(act_fill[0]), 64'd0);
    chk("t6_data", 0, 64'(act_co[0]),   64'd0);
    repeat (4) begin
      tick();
      chk("t6_no_done", 0, 64'(act_done[0]), 64'd0);
    end

    // Parity tail bit (data bit 37 when parity is off)
    capture(0, 38'h7);
    st = col_n[0];
    run_dump(0, -1, 1'b0, nv);
    chk("t6_plen", 0, 64'(nv), 64'(SH_A));
    chk("t6_pbit", 0, 64'(col[0][(st + SH_A - 1) % 4096][0]), 64'(PAR));
    tick();

    // Randomised traffic on both instances
    for (int it = 0; it < 40; it++) begin
      int i = it % 2;
      int n = $urandom_range(0, 11);
      for (int k = 0; k < n; k++) begin
        cap_en[i] = ($urandom_range(0, 3) != 0);
        din_v[i]  = rand38();
        tick();
      end
      cap_en[i] = ($urandom_range(0, 1) == 1);
      din_v[i]  = rand38();
      run_dump(i, -1, 1'b1, nv);
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
